// File: rtl/alu_operand_loader_pkg.sv
// Shared types for the operand loader feeding the 8-bit carry-lookahead adder.
// Holds the loader state encoding, the default data width and the overflow helper.
package alu_pkg;

  localparam int NB_DATA_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD_B = 2'd1,
    S_EXEC   = 2'd2,
    S_DONE   = 2'd3
  } loader_state_t;

  // Two's-complement overflow: operands agree in sign but the sum does not.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_operand_loader_if.sv
// Bus bundle between the operand loader, its producer, the adder and the result consumer.
// Slave modport is the loader's view; master modport is the surrounding environment.
interface alu_operand_loader_if #(
  parameter int NB_DATA = 8
);

  // Valid/ready: a transfer happens on a rising edge where both valid and ready are high;
  // valid may not depend on ready, and data is held stable while valid is high and ready is low.
  logic [NB_DATA-1:0] i_data;
  logic               i_cin;
  logic               i_valid;
  logic               o_ready;

  logic [NB_DATA-1:0] o_add1;
  logic [NB_DATA-1:0] o_add2;
  logic               o_carry;
  logic [NB_DATA-1:0] i_sum;
  logic               i_cout;

  logic [NB_DATA-1:0] o_result;
  logic               o_cout;
  logic               o_res_valid;
  logic               i_res_ready;

  modport slave (
    input  i_data, i_cin, i_valid, i_sum, i_cout, i_res_ready,
    output o_ready, o_add1, o_add2, o_carry, o_result, o_cout, o_res_valid
  );

  modport master (
    output i_data, i_cin, i_valid, i_sum, i_cout, i_res_ready,
    input  o_ready, o_add1, o_add2, o_carry, o_result, o_cout, o_res_valid
  );

endinterface

// File: rtl/alu_operand_reg.sv
// Operand holding register: load enable with a synchronous clear that wins over the load.
module alu_operand_reg #(
  parameter int NB_DATA = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_clr,
  input  logic               i_en,
  input  logic [NB_DATA-1:0] i_d,
  output logic [NB_DATA-1:0] o_q
);

  logic [NB_DATA-1:0] val_q;
  logic [NB_DATA-1:0] val_d;

  always_comb begin
    val_d = val_q;
    if (i_clr) begin
      val_d = '0;
    end else if (i_en) begin
      val_d = i_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign o_q = val_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Loads A then B (+carry-in) from one valid/ready bus, holds them on the adder, captures sum/carry-out.
// Optional macro ALU_LOADER_OVF_EN adds o_ovf, the captured signed overflow flag.
module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_clear,
  alu_operand_loader_if.slave  bus,
`ifdef ALU_LOADER_OVF_EN
  output logic                 o_ovf,
`endif
  output loader_state_t        o_dbg_state
);

  localparam int MSB = NB_DATA - 1;

  loader_state_t      state_q, state_d;
  logic               carry_q, carry_d;
  logic [NB_DATA-1:0] result_q, result_d;
  logic               cout_q, cout_d;
  logic               res_valid_q, res_valid_d;
`ifdef ALU_LOADER_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic ready;
  logic beat;
  logic load_a;
  logic load_b;

  assign ready  = (state_q == S_IDLE) || (state_q == S_LOAD_B);
  assign beat   = bus.i_valid & ready;
  assign load_a = beat & (state_q == S_IDLE);
  assign load_b = beat & (state_q == S_LOAD_B);

  // Clear wins inside the registers too, so a beat coinciding with i_clear is dropped.
  alu_operand_reg #(.NB_DATA(NB_DATA)) u_reg_a (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (i_clear),
    .i_en    (load_a),
    .i_d     (bus.i_data),
    .o_q     (bus.o_add1)
  );

  alu_operand_reg #(.NB_DATA(NB_DATA)) u_reg_b (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (i_clear),
    .i_en    (load_b),
    .i_d     (bus.i_data),
    .o_q     (bus.o_add2)
  );

  always_comb begin
    state_d     = state_q;
    carry_d     = carry_q;
    result_d    = result_q;
    cout_d      = cout_q;
    res_valid_d = res_valid_q;
`ifdef ALU_LOADER_OVF_EN
    ovf_d       = ovf_q;
`endif
    if (i_clear) begin
      // Captured result/flags survive an abort; only the handshake and operands reset.
      state_d     = S_IDLE;
      carry_d     = 1'b0;
      res_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (beat) state_d = S_LOAD_B;
        end
        S_LOAD_B: begin
          if (beat) begin
            carry_d = bus.i_cin;
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          result_d    = bus.i_sum;
          cout_d      = bus.i_cout;
          res_valid_d = 1'b1;
`ifdef ALU_LOADER_OVF_EN
          ovf_d       = signed_ovf(bus.o_add1[MSB], bus.o_add2[MSB], bus.i_sum[MSB]);
`endif
          state_d     = S_DONE;
        end
        S_DONE: begin
          if (res_valid_q && bus.i_res_ready) begin
            res_valid_d = 1'b0;
            state_d     = S_IDLE;
          end
        end
        default: begin
          state_d     = S_IDLE;
          res_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      carry_q     <= 1'b0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      res_valid_q <= 1'b0;
`ifdef ALU_LOADER_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      cout_q      <= cout_d;
      res_valid_q <= res_valid_d;
`ifdef ALU_LOADER_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign bus.o_ready     = ready;
  assign bus.o_carry     = carry_q;
  assign bus.o_result    = result_q;
  assign bus.o_cout      = cout_q;
  assign bus.o_res_valid = res_valid_q;
  assign o_dbg_state     = state_q;
`ifdef ALU_LOADER_OVF_EN
  assign o_ovf           = ovf_q;
`endif

endmodule

// File: tb/tb_alu_operand_loader.sv
// Bench for alu_operand_loader paired with a behavioural 8-bit adder; directed cases then random traffic.
// Build with ALU_LOADER_OVF_EN defined to also exercise o_ovf.
module tb_alu_operand_loader;
  import alu_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  loader_state_t dbg_state;
`ifdef ALU_LOADER_OVF_EN
  logic ovf;
`endif

  alu_operand_loader_if #(.NB_DATA(W)) bus();

  // Combinational adder standing in for the carry-lookahead adder.
  assign {bus.i_cout, bus.i_sum} = {1'b0, bus.o_add1} + {1'b0, bus.o_add2} + {{W{1'b0}}, bus.o_carry};

  alu_operand_loader #(.NB_DATA(W)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_clear     (clear),
    .bus         (bus),
`ifdef ALU_LOADER_OVF_EN
    .o_ovf       (ovf),
`endif
    .o_dbg_state (dbg_state)
  );

  // ---------------- behavioural model ----------------
  // ph counts progress of one transaction: 0 awaiting A, 1 awaiting B, 2 adding, 3 result offered.
  int           ph = 0;
  logic [W-1:0] m_a, m_b, m_res;
  logic         m_c, m_cout, m_rv, m_ovf;
  logic [W:0]   m_s9;
  logic [W:0]   exp_q[$];

  assign m_s9 = {1'b0, m_a} + {1'b0, m_b} + {{W{1'b0}}, m_c};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph <= 0; m_a <= '0; m_b <= '0; m_c <= 1'b0;
      m_res <= '0; m_cout <= 1'b0; m_rv <= 1'b0; m_ovf <= 1'b0;
      exp_q.delete();
    end else if (clear) begin
      ph <= 0; m_a <= '0; m_b <= '0; m_c <= 1'b0; m_rv <= 1'b0;
      exp_q.delete();
    end else begin
      case (ph)
        0: if (bus.i_valid) begin m_a <= bus.i_data; ph <= 1; end
        1: if (bus.i_valid) begin
             m_b <= bus.i_data; m_c <= bus.i_cin; ph <= 2;
             exp_q.push_back({1'b0, m_a} + {1'b0, bus.i_data} + {{W{1'b0}}, bus.i_cin});
           end
        2: begin
             m_res  <= m_s9[W-1:0];
             m_cout <= m_s9[W];
             m_ovf  <= (m_a[W-1] == m_b[W-1]) && (m_s9[W-1] != m_a[W-1]);
             m_rv   <= 1'b1;
             ph     <= 3;
           end
        default: if (bus.i_res_ready) begin m_rv <= 1'b0; ph <= 0; end
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [W:0] e;
    chk("ready",     {31'd0, bus.o_ready},     {31'd0, (ph < 2)});
    chk("res_valid", {31'd0, bus.o_res_valid}, {31'd0, m_rv});
    chk("add1",      {24'd0, bus.o_add1},      {24'd0, m_a});
    chk("add2",      {24'd0, bus.o_add2},      {24'd0, m_b});
    chk("carry",     {31'd0, bus.o_carry},     {31'd0, m_c});
    chk("result",    {24'd0, bus.o_result},    {24'd0, m_res});
    chk("cout",      {31'd0, bus.o_cout},      {31'd0, m_cout});
`ifdef ALU_LOADER_OVF_EN
    chk("ovf",       {31'd0, ovf},             {31'd0, m_ovf});
`endif
    if (m_rv && bus.i_res_ready && !clear && !rst) begin
      if (exp_q.size() == 0) begin
        chk("handoff_queue_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("handoff", {23'd0, bus.o_cout, bus.o_result}, {23'd0, e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic beat(input logic [W-1:0] d, input logic c);
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    bus.i_cin   = c;
    step();
    bus.i_valid = 1'b0;
  endtask

  task automatic take_result();
    step();
    bus.i_res_ready = 1'b1;
    step();
    bus.i_res_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.i_valid     = 1'b0;
    bus.i_data      = '0;
    bus.i_cin       = 1'b0;
    bus.i_res_ready = 1'b0;
    #1 rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();

    // Reset in the middle of a transaction
    beat(8'h12, 1'b0);
    @(negedge clk);
    chk("t1_add1_loaded", {24'd0, bus.o_add1}, 32'h12);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    chk("t1_state_idle", {30'd0, dbg_state}, {30'd0, S_IDLE});
    chk("t1_add1_zero",  {24'd0, bus.o_add1}, 32'h0);
    chk("t1_no_valid",   {31'd0, bus.o_res_valid}, 32'h0);
    chk("t1_ready",      {31'd0, bus.o_ready}, 32'h1);
    step();

    // Basic add and its latency
    beat(8'h3C, 1'b0);
    beat(8'h05, 1'b0);
    @(negedge clk);
    chk("t2_not_yet_valid", {31'd0, bus.o_res_valid}, 32'h0);
    step();
    @(negedge clk);
    chk("t2_valid", {31'd0, bus.o_res_valid}, 32'h1);
    chk("t2_result", {24'd0, bus.o_result}, 32'h41);
    chk("t2_cout", {31'd0, bus.o_cout}, 32'h0);
    take_result();
    @(negedge clk);
    chk("t2_handed_off", {31'd0, bus.o_res_valid}, 32'h0);
    step();

    // Carry out
    beat(8'hFF, 1'b1);
    beat(8'h01, 1'b1);
    step();
    @(negedge clk);
    chk("t3_result", {24'd0, bus.o_result}, 32'h01);
    chk("t3_cout", {31'd0, bus.o_cout}, 32'h1);
`ifdef ALU_LOADER_OVF_EN
    chk("t3_ovf", {31'd0, ovf}, 32'h0);
`endif
    take_result();

    // Backpressure with extra beats presented
    beat(8'h20, 1'b0);
    beat(8'h30, 1'b1);
    step();
    for (int i = 0; i < 5; i++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = W'($urandom);
      @(negedge clk);
      chk("t4_held_result", {24'd0, bus.o_result}, 32'h51);
      chk("t4_held_valid", {31'd0, bus.o_res_valid}, 32'h1);
      chk("t4_not_ready", {31'd0, bus.o_ready}, 32'h0);
      step();
    end
    bus.i_valid     = 1'b0;
    bus.i_res_ready = 1'b1;
    step();
    bus.i_res_ready = 1'b0;
    @(negedge clk);
    chk("t4_handoff_done", {31'd0, bus.o_res_valid}, 32'h0);
    chk("t4_operand_kept", {24'd0, bus.o_add2}, 32'h30);
    step();

    // Clear coinciding with the B beat
    beat(8'h11, 1'b0);
    bus.i_valid = 1'b1;
    bus.i_data  = 8'h77;
    bus.i_cin   = 1'b1;
    clear       = 1'b1;
    step();
    bus.i_valid = 1'b0;
    clear       = 1'b0;
    @(negedge clk);
    chk("t5_state_idle", {30'd0, dbg_state}, {30'd0, S_IDLE});
    chk("t5_add2_zero", {24'd0, bus.o_add2}, 32'h0);
    chk("t5_result_kept", {24'd0, bus.o_result}, 32'h51);
    repeat (3) begin
      step();
      @(negedge clk);
      chk("t5_no_valid", {31'd0, bus.o_res_valid}, 32'h0);
    end
    step();

`ifdef ALU_LOADER_OVF_EN
    // Signed overflow
    beat(8'h7F, 1'b0);
    beat(8'h01, 1'b0);
    step();
    @(negedge clk);
    chk("t6_result", {24'd0, bus.o_result}, 32'h80);
    chk("t6_cout", {31'd0, bus.o_cout}, 32'h0);
    chk("t6_ovf", {31'd0, ovf}, 32'h1);
    take_result();
`endif

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst             = ($urandom_range(0, 149) == 0);
      clear           = ($urandom_range(0, 29) == 0);
      bus.i_valid     = 1'($urandom_range(0, 1));
      bus.i_data      = W'($urandom);
      bus.i_cin       = 1'($urandom_range(0, 1));
      bus.i_res_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    rst             = 1'b0;
    clear           = 1'b0;
    bus.i_valid     = 1'b0;
    bus.i_res_ready = 1'b1;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
